// File: rtl/smg_scan_encode_module.sv
// 4-digit multiplexed 7-segment scanner and hex encoder, slot-locked to the digit sequencer.
// Optional anti-ghost digit blanking is enabled by defining SMG_GHOST_BLANK_EN.
module smg_scan_encode_module #(
   parameter logic [18:0] T1MS         = 19'd500_000,
   parameter bit          COMMON_ANODE = 1'b1,
   parameter logic [18:0] BLANK_CYC    = 19'd1000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [3:0] NumberData,
   input  logic [3:0] DpMask,
   output logic [3:0] DigSel,
   output logic [7:0] SegData,
   output logic [1:0] SlotIdx
);

`ifdef SMG_GHOST_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   localparam logic [3:0] DIG_OFF = COMMON_ANODE ? 4'hF : 4'h0;
   localparam logic [7:0] SEG_OFF = COMMON_ANODE ? 8'hFF : 8'h00;

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2,
      SLOT3 = 2'd3
   } slotState_t;

   slotState_t  slotState, slotNext;
   logic [18:0] c1, c1Next;
   logic        slotEnd;
   logic [3:0]  digActive, digNext;
   logic [7:0]  segActive, segNext;
   logic        blankNow;

   // Active-high one-hot enable; bit3 is the leftmost digit, matching DpMask.
   function automatic logic [3:0] digOneHot(input slotState_t s);
      logic [3:0] r;
      r = 4'b0000;
      case (s)
         SLOT0:   r = 4'b1000;
         SLOT1:   r = 4'b0100;
         SLOT2:   r = 4'b0010;
         SLOT3:   r = 4'b0001;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   // Active-high gfedcba hex font.
   function automatic logic [6:0] hexFont(input logic [3:0] n);
      logic [6:0] r;
      r = 7'h00;
      case (n)
         4'h0: r = 7'h3F;
         4'h1: r = 7'h06;
         4'h2: r = 7'h5B;
         4'h3: r = 7'h4F;
         4'h4: r = 7'h66;
         4'h5: r = 7'h6D;
         4'h6: r = 7'h7D;
         4'h7: r = 7'h07;
         4'h8: r = 7'h7F;
         4'h9: r = 7'h6F;
         4'hA: r = 7'h77;
         4'hB: r = 7'h7C;
         4'hC: r = 7'h39;
         4'hD: r = 7'h5E;
         4'hE: r = 7'h79;
         4'hF: r = 7'h71;
         default: r = 7'h00;
      endcase
      return r;
   endfunction

   assign slotEnd = (c1 == T1MS);
   assign c1Next  = slotEnd ? 19'd0 : c1 + 19'd1;

   always_comb begin
      slotNext = slotState;
      if (slotEnd) begin
         case (slotState)
            SLOT0:   slotNext = SLOT1;
            SLOT1:   slotNext = SLOT2;
            SLOT2:   slotNext = SLOT3;
            SLOT3:   slotNext = SLOT0;
            default: slotNext = SLOT0;
         endcase
      end
   end

   // Outputs are computed from next-state values so registered pins line up with the C1/slot registers.
   always_comb begin
      blankNow  = BLANK_EN && (c1Next < BLANK_CYC);
      digActive = blankNow ? 4'b0000 : digOneHot(slotNext);
      digNext   = COMMON_ANODE ? ~digActive : digActive;
      segActive = {|(digOneHot(slotNext) & DpMask), hexFont(NumberData)};
      segNext   = COMMON_ANODE ? ~segActive : segActive;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         c1        <= 19'd0;
         slotState <= SLOT0;
         DigSel    <= DIG_OFF;
         SegData   <= SEG_OFF;
      end else begin
         c1        <= c1Next;
         slotState <= slotNext;
         DigSel    <= digNext;
         SegData   <= segNext;
      end
   end

   assign SlotIdx = slotState;

endmodule

// File: tb/tb_smg_scan_encode_module.sv
// Directed bench for smg_scan_encode_module with T1MS=9 (10-cycle slots) and BLANK_CYC=3.
module tb_smg_scan_encode_module;

`ifdef SMG_GHOST_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic       CLK;
   logic       RSTn;
   logic [3:0] NumberData;
   logic [3:0] DpMask;
   logic [3:0] DigSel;
   logic [7:0] SegData;
   logic [1:0] SlotIdx;

   int checks;
   int failures;

   smg_scan_encode_module #(
      .T1MS        (19'd9),
      .COMMON_ANODE(1'b1),
      .BLANK_CYC   (19'd3)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .NumberData(NumberData),
      .DpMask    (DpMask),
      .DigSel    (DigSel),
      .SegData   (SegData),
      .SlotIdx   (SlotIdx)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected DigSel given the selected pattern and the C1 value during that cycle.
   function automatic logic [7:0] expDig(input logic [3:0] sel, input int c1);
      if (BLANK && c1 < 3) return 8'h0F;
      return {4'h0, sel};
   endfunction

   initial begin
      checks     = 0;
      failures   = 0;
      RSTn       = 1'b0;
      NumberData = 4'h0;
      DpMask     = 4'h0;

      // 1: reset state and release
      tick(2);
      check("rst_digsel", {4'h0, DigSel}, 8'h0F);
      check("rst_segdata", SegData, 8'hFF);
      check("rst_slot", {6'h0, SlotIdx}, 8'h00);
      RSTn = 1'b1;
      tick(1);                                   // E1: C1=1 slot0
      check("first_digsel", {4'h0, DigSel}, expDig(4'h7, 1));
      check("first_slot", {6'h0, SlotIdx}, 8'h00);

      // 2: encoding with one cycle latency
      check("seg_0", SegData, 8'hC0);
      NumberData = 4'h8;
      #1;
      check("seg_latency", SegData, 8'hC0);
      tick(1);                                   // E2
      check("seg_8", SegData, 8'h80);
      NumberData = 4'hF;
      tick(1);                                   // E3
      check("seg_F", SegData, 8'h8E);

      // 3: free-running scan
      tick(6);                                   // E9: C1=9 slot0
      check("e9_slot", {6'h0, SlotIdx}, 8'h00);
      check("e9_dig", {4'h0, DigSel}, expDig(4'h7, 9));
      tick(1);                                   // E10: slot1
      check("e10_slot", {6'h0, SlotIdx}, 8'h01);
      check("e10_dig", {4'h0, DigSel}, expDig(4'hB, 0));
      tick(9);                                   // E19
      check("e19_slot", {6'h0, SlotIdx}, 8'h01);
      check("e19_dig", {4'h0, DigSel}, expDig(4'hB, 9));
      tick(1);                                   // E20: slot2
      check("e20_slot", {6'h0, SlotIdx}, 8'h02);
      check("e20_dig", {4'h0, DigSel}, expDig(4'hD, 0));
      tick(10);                                  // E30: slot3
      check("e30_slot", {6'h0, SlotIdx}, 8'h03);
      check("e30_dig", {4'h0, DigSel}, expDig(4'hE, 0));
      tick(10);                                  // E40: slot0
      check("e40_slot", {6'h0, SlotIdx}, 8'h00);
      check("e40_dig", {4'h0, DigSel}, expDig(4'h7, 0));

      // 4: decimal point only on slot1
      DpMask     = 4'b0100;
      NumberData = 4'h1;
      tick(1);                                   // E41: slot0
      check("dp_slot0", SegData, 8'hF9);
      tick(9);                                   // E50: slot1
      check("dp_slot1_start", SegData, 8'h79);
      tick(9);                                   // E59: slot1 end
      check("dp_slot1_end", SegData, 8'h79);
      tick(1);                                   // E60: slot2
      check("dp_slot2", SegData, 8'hF9);
      tick(10);                                  // E70: slot3
      check("dp_slot3", SegData, 8'hF9);
      tick(10);                                  // E80: slot0
      check("dp_slot0_again", SegData, 8'hF9);

      // 5: reset mid-slot at C1=5 of slot2
      tick(25);                                  // E105
      check("pre_rst_slot", {6'h0, SlotIdx}, 8'h02);
      check("pre_rst_dig", {4'h0, DigSel}, expDig(4'hD, 5));
      RSTn = 1'b0;
      #1;
      check("midrst_dig", {4'h0, DigSel}, 8'h0F);
      check("midrst_seg", SegData, 8'hFF);
      check("midrst_slot", {6'h0, SlotIdx}, 8'h00);
      tick(1);
      check("midrst_hold_dig", {4'h0, DigSel}, 8'h0F);
      RSTn = 1'b1;
      tick(1);                                   // R1: C1=1 slot0
      check("r1_slot", {6'h0, SlotIdx}, 8'h00);
      check("r1_dig", {4'h0, DigSel}, expDig(4'h7, 1));
      check("r1_seg", SegData, 8'hF9);
      tick(8);                                   // R9
      check("r9_slot", {6'h0, SlotIdx}, 8'h00);
      check("r9_dig", {4'h0, DigSel}, expDig(4'h7, 9));
      tick(1);                                   // R10: slot1
      check("r10_slot", {6'h0, SlotIdx}, 8'h01);

      // 6: per-cycle DigSel across one slot (blanking when enabled)
      check("slot1_c0_dig", {4'h0, DigSel}, expDig(4'hB, 0));
      for (int i = 1; i < 10; i++) begin
         tick(1);
         check($sformatf("slot1_c%0d_dig", i), {4'h0, DigSel}, expDig(4'hB, i));
      end
      tick(1);                                   // R20: slot2
      check("r20_slot", {6'h0, SlotIdx}, 8'h02);
      check("r20_dig", {4'h0, DigSel}, expDig(4'hD, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
